// File: rtl/instr_pkg.sv
// Shared types and RV32I encoding constants for the instruction encoder.
// The pack helpers place already-range-checked fields into the standard formats.
package instr_pkg;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0, OP_ADDI, OP_SUB, OP_AND, OP_ANDI, OP_OR, OP_ORI,
        OP_XOR, OP_XORI, OP_SLL, OP_SLLI, OP_LW, OP_LH, OP_LB, OP_SB,
        OP_SH, OP_SW, OP_BEQ, OP_BNE, OP_BGE, OP_BLT, OP_LUI, OP_AUIPC,
        OP_JAL, OP_JALR, OP_EBREAK = 5'd25
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

    localparam logic [6:0] OPC_R     = 7'h33;
    localparam logic [6:0] OPC_I     = 7'h13;
    localparam logic [6:0] OPC_LOAD  = 7'h03;
    localparam logic [6:0] OPC_STORE = 7'h23;
    localparam logic [6:0] OPC_BR    = 7'h63;
    localparam logic [6:0] OPC_LUI   = 7'h37;
    localparam logic [6:0] OPC_AUIPC = 7'h17;
    localparam logic [6:0] OPC_JAL   = 7'h6F;
    localparam logic [6:0] OPC_JALR  = 7'h67;
    localparam logic [6:0] OPC_SYS   = 7'h73;

    localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_XOR = 3'd4;
    localparam logic [2:0] F3_OR  = 3'd6, F3_AND = 3'd7;
    localparam logic [2:0] F3_B = 3'd0, F3_H = 3'd1, F3_W = 3'd2;
    localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE = 3'd5;

    localparam logic [6:0] F7_ZERO = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPC_R};
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] i, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] opc);
        return {i, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(logic [11:0] s, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {s[11:5], rs2, rs1, f3, s[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] enc_b(logic [12:1] b, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {b[12], b[10:5], rs2, rs1, f3, b[4:1], b[11], OPC_BR};
    endfunction

    function automatic logic [31:0] enc_u(logic [19:0] u, logic [4:0] rd, logic [6:0] opc);
        return {u, rd, opc};
    endfunction

    function automatic logic [31:0] enc_j(logic [20:1] j, logic [4:0] rd);
        return {j[20], j[10:1], j[11], j[19:12], rd, OPC_JAL};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: symbolic fields in, 32-bit RV32I word and illegal flag out.
module instr_pack
    import instr_pkg::*;
(
    input  logic [4:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    logic i_ok, b_ok, j_ok, u_ok, sh_ok;

    // Range checks reduce to "upper bits are a pure sign extension".
    assign i_ok  = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign b_ok  = ((&imm_i[31:12]) | ~(|imm_i[31:12])) & ~imm_i[0];
    assign j_ok  = ((&imm_i[31:20]) | ~(|imm_i[31:20])) & ~imm_i[0];
    assign u_ok  = ~(|imm_i[31:20]);
    assign sh_ok = ~(|imm_i[31:5]);

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (op_i)
            OP_ADD:  word_o = enc_r(F7_ZERO, rs2_i, rs1_i, F3_ADD, rd_i);
            OP_SUB:  word_o = enc_r(F7_ALT,  rs2_i, rs1_i, F3_ADD, rd_i);
            OP_AND:  word_o = enc_r(F7_ZERO, rs2_i, rs1_i, F3_AND, rd_i);
            OP_OR:   word_o = enc_r(F7_ZERO, rs2_i, rs1_i, F3_OR,  rd_i);
            OP_XOR:  word_o = enc_r(F7_ZERO, rs2_i, rs1_i, F3_XOR, rd_i);
            OP_SLL:  word_o = enc_r(F7_ZERO, rs2_i, rs1_i, F3_SLL, rd_i);
            OP_ADDI: begin word_o = enc_i(imm_i[11:0], rs1_i, F3_ADD, rd_i, OPC_I);    illegal_o = ~i_ok; end
            OP_ANDI: begin word_o = enc_i(imm_i[11:0], rs1_i, F3_AND, rd_i, OPC_I);    illegal_o = ~i_ok; end
            OP_ORI:  begin word_o = enc_i(imm_i[11:0], rs1_i, F3_OR,  rd_i, OPC_I);    illegal_o = ~i_ok; end
            OP_XORI: begin word_o = enc_i(imm_i[11:0], rs1_i, F3_XOR, rd_i, OPC_I);    illegal_o = ~i_ok; end
            OP_SLLI: begin word_o = enc_i({7'd0, imm_i[4:0]}, rs1_i, F3_SLL, rd_i, OPC_I); illegal_o = ~sh_ok; end
            OP_LW:   begin word_o = enc_i(imm_i[11:0], rs1_i, F3_W, rd_i, OPC_LOAD);   illegal_o = ~i_ok; end
            OP_LH:   begin word_o = enc_i(imm_i[11:0], rs1_i, F3_H, rd_i, OPC_LOAD);   illegal_o = ~i_ok; end
            OP_LB:   begin word_o = enc_i(imm_i[11:0], rs1_i, F3_B, rd_i, OPC_LOAD);   illegal_o = ~i_ok; end
            OP_JALR: begin word_o = enc_i(imm_i[11:0], rs1_i, F3_ADD, rd_i, OPC_JALR); illegal_o = ~i_ok; end
            OP_SB:   begin word_o = enc_s(imm_i[11:0], rs2_i, rs1_i, F3_B); illegal_o = ~i_ok; end
            OP_SH:   begin word_o = enc_s(imm_i[11:0], rs2_i, rs1_i, F3_H); illegal_o = ~i_ok; end
            OP_SW:   begin word_o = enc_s(imm_i[11:0], rs2_i, rs1_i, F3_W); illegal_o = ~i_ok; end
            OP_BEQ:  begin word_o = enc_b(imm_i[12:1], rs2_i, rs1_i, F3_BEQ); illegal_o = ~b_ok; end
            OP_BNE:  begin word_o = enc_b(imm_i[12:1], rs2_i, rs1_i, F3_BNE); illegal_o = ~b_ok; end
            OP_BGE:  begin word_o = enc_b(imm_i[12:1], rs2_i, rs1_i, F3_BGE); illegal_o = ~b_ok; end
            OP_BLT:  begin word_o = enc_b(imm_i[12:1], rs2_i, rs1_i, F3_BLT); illegal_o = ~b_ok; end
            OP_LUI:  begin word_o = enc_u(imm_i[19:0], rd_i, OPC_LUI);   illegal_o = ~u_ok; end
            OP_AUIPC: begin word_o = enc_u(imm_i[19:0], rd_i, OPC_AUIPC); illegal_o = ~u_ok; end
            OP_JAL:  begin word_o = enc_j(imm_i[20:1], rd_i); illegal_o = ~j_ok; end
            OP_EBREAK: word_o = EBREAK_WORD;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts symbolic instructions, encodes them and streams the
// words into consecutive instruction-memory addresses via a stallable write port.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            op,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [31:0]           imm,
    output logic                  im_we,
    input  logic                  im_ready,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [31:0]           im_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH:0] LAST_CNT = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic                  ebrk_q, ebrk_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [31:0] word;
    logic        illegal, fire, term, accept;

    instr_pack u_pack (
        .op_i      (op),
        .rd_i      (rd),
        .rs1_i     (rs1),
        .rs2_i     (rs2),
        .imm_i     (imm),
        .word_o    (word),
        .illegal_o (illegal)
    );

    assign fire = we_q && im_ready;
    assign term = fire && (ebrk_q || cnt_q == LAST_CNT);
    // Refuse new input on the terminal-write edge; it could never be written.
    assign in_ready = (state_q == S_RUN) && !start && (!we_q || im_ready) && !term;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        ebrk_d  = ebrk_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        err_d   = err_q;
        if (start) begin
            state_d = S_RUN;
            we_d    = 1'b0;
            ebrk_d  = 1'b0;
            addr_d  = base_addr;
            cnt_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            if (fire) begin
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q + 1'b1;
                we_d   = 1'b0;
                if (term) begin
                    done_d  = 1'b1;
                    state_d = S_HALT;
                end
            end
            if (accept) begin
                if (illegal) begin
                    err_d = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    wdata_d = word;
                    ebrk_d  = (op == OP_EBREAK);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            ebrk_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            ebrk_q  <= ebrk_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign im_we    = we_q;
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign count    = cnt_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-encoded RV32I words.
module tb_instr_encoder;
    import instr_pkg::*;

    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    op = '0, rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0]   imm = '0;
    logic          im_we;
    logic          im_ready = 1'b0;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic [AW:0]   count;
    logic          done, err;

    int total = 0;
    int bad = 0;

    instr_encoder #(.ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .rd(rd), .rs1(rs1),
        .rs2(rs2), .imm(imm), .im_we(im_we), .im_ready(im_ready),
        .im_addr(im_addr), .im_wdata(im_wdata), .count(count), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [4:0] o, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] i);
        in_valid = 1'b1; op = o; rd = d; rs1 = s1; rs2 = s2; imm = i;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b);
        start = 1'b1; base_addr = b;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (im_we !== 1'b0)    begin bad++; $display("FAIL reset_we got=%0b exp=0", im_we); end
        total++; if (im_addr !== '0)    begin bad++; $display("FAIL reset_addr got=%0h exp=0", im_addr); end
        total++; if (im_wdata !== '0)   begin bad++; $display("FAIL reset_wdata got=%08h exp=0", im_wdata); end
        total++; if (count !== '0)      begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if ({done, err} !== 2'b00) begin bad++; $display("FAIL reset_done_err got=%b exp=00", {done, err}); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        step(); reset = 1'b1; step();
    endtask

    task automatic test_addi();
        pulse_start(8'h10);
        im_ready = 1'b1;
        drive(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL addi_ready got=%0b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (im_we !== 1'b1) begin bad++; $display("FAIL addi_we got=%0b exp=1", im_we); end
        total++; if (im_addr !== 8'h10) begin bad++; $display("FAIL addi_addr got=%0h exp=10", im_addr); end
        total++; if (im_wdata !== 32'h00500093) begin bad++; $display("FAIL addi_word got=%08h exp=00500093", im_wdata); end
        total++; if (count !== 9'd0) begin bad++; $display("FAIL addi_count0 got=%0d exp=0", count); end
        step();
        total++; if (count !== 9'd1) begin bad++; $display("FAIL addi_count1 got=%0d exp=1", count); end
        total++; if (im_we !== 1'b0 || im_addr !== 8'h11) begin bad++; $display("FAIL addi_after got we=%0b addr=%0h exp we=0 addr=11", im_we, im_addr); end
    endtask

    task automatic test_back_to_back();
        drive(OP_ADD, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF);
        step();
        total++; if (im_wdata !== 32'h002081B3 || im_addr !== 8'h11) begin bad++; $display("FAIL b2b_add got=%08h@%0h exp=002081B3@11", im_wdata, im_addr); end
        drive(OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0);
        step();
        in_valid = 1'b0;
        total++; if (im_we !== 1'b1 || im_wdata !== 32'h402081B3 || im_addr !== 8'h12) begin bad++; $display("FAIL b2b_sub got we=%0b %08h@%0h exp 1 402081B3@12", im_we, im_wdata, im_addr); end
        total++; if (count !== 9'd2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", count); end
        step();
        total++; if (count !== 9'd3 || im_we !== 1'b0) begin bad++; $display("FAIL b2b_end got cnt=%0d we=%0b exp 3 0", count, im_we); end
    endtask

    task automatic test_stall();
        im_ready = 1'b0;
        drive(OP_BEQ, 5'd0, 5'd1, 5'd2, -32'sd4);
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (im_we !== 1'b1 || im_wdata !== 32'hFE208EE3 || in_ready !== 1'b0 || count !== 9'd3)
                begin bad++; $display("FAIL stall_hold c=%0d got we=%0b %08h rdy=%0b cnt=%0d exp 1 FE208EE3 0 3", c, im_we, im_wdata, in_ready, count); end
            step();
        end
        im_ready = 1'b1;
        step();
        total++; if (count !== 9'd4 || im_we !== 1'b0 || im_addr !== 8'h14) begin bad++; $display("FAIL stall_release got cnt=%0d we=%0b addr=%0h exp 4 0 14", count, im_we, im_addr); end
    endtask

    task automatic test_ebreak();
        drive(OP_JAL, 5'd1, 5'd0, 5'd0, 32'd8);
        step();
        total++; if (im_wdata !== 32'h008000EF) begin bad++; $display("FAIL jal_word got=%08h exp=008000EF", im_wdata); end
        drive(OP_EBREAK, 5'd0, 5'd0, 5'd0, 32'd0);
        step();
        in_valid = 1'b0;
        total++; if (im_wdata !== 32'h00100073 || done !== 1'b0) begin bad++; $display("FAIL ebreak_word got=%08h done=%0b exp=00100073 0", im_wdata, done); end
        step();
        total++; if (done !== 1'b1 || count !== 9'd6 || im_we !== 1'b0) begin bad++; $display("FAIL ebreak_done got done=%0b cnt=%0d we=%0b exp 1 6 0", done, count, im_we); end
        drive(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd1);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL halt_ready got=%0b exp=0", in_ready); end
        step(); step();
        in_valid = 1'b0;
        total++; if (im_we !== 1'b0 || count !== 9'd6 || done !== 1'b1) begin bad++; $display("FAIL halt_ignore got we=%0b cnt=%0d done=%0b exp 0 6 1", im_we, count, done); end
    endtask

    task automatic test_err();
        pulse_start(8'h40);
        total++; if (done !== 1'b0 || count !== 9'd0 || im_addr !== 8'h40) begin bad++; $display("FAIL restart got done=%0b cnt=%0d addr=%0h exp 0 0 40", done, count, im_addr); end
        drive(OP_LUI, 5'd5, 5'd0, 5'd0, 32'h12345);
        step();
        total++; if (im_wdata !== 32'h123452B7 || err !== 1'b0) begin bad++; $display("FAIL lui_word got=%08h err=%0b exp=123452B7 0", im_wdata, err); end
        drive(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd4096);
        step();
        total++; if (err !== 1'b1 || im_we !== 1'b0 || count !== 9'd1) begin bad++; $display("FAIL imm_range got err=%0b we=%0b cnt=%0d exp 1 0 1", err, im_we, count); end
        drive(5'd30, 5'd1, 5'd0, 5'd0, 32'd0);
        step();
        in_valid = 1'b0;
        total++; if (err !== 1'b1 || im_we !== 1'b0 || count !== 9'd1) begin bad++; $display("FAIL bad_op got err=%0b we=%0b cnt=%0d exp 1 0 1", err, im_we, count); end
        pulse_start(8'h00);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%0b exp=0", err); end
    endtask

    task automatic test_wrap();
        int stop_i;
        stop_i = -1;
        pulse_start(8'hFF);
        drive(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        for (int i = 0; i < 400; i++) begin
            step();
            if (i == 0) begin
                total++; if (im_addr !== 8'hFF) begin bad++; $display("FAIL wrap_first got=%0h exp=FF", im_addr); end
            end
            if (i == 1) begin
                total++; if (im_addr !== 8'h00 || count !== 9'd1) begin bad++; $display("FAIL wrap_second got addr=%0h cnt=%0d exp 0 1", im_addr, count); end
            end
            if (done === 1'b1) begin stop_i = i; break; end
        end
        in_valid = 1'b0;
        total++; if (stop_i != 256) begin bad++; $display("FAIL full_done got cycle=%0d exp=256", stop_i); end
        total++; if (count !== 9'd256 || im_we !== 1'b0) begin bad++; $display("FAIL full_count got cnt=%0d we=%0b exp 256 0", count, im_we); end
    endtask

    task automatic test_start_drop();
        im_ready = 1'b0;
        pulse_start(8'h20);
        drive(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        step();
        in_valid = 1'b0;
        total++; if (im_we !== 1'b1 || im_addr !== 8'h20) begin bad++; $display("FAIL drop_pending got we=%0b addr=%0h exp 1 20", im_we, im_addr); end
        step();
        pulse_start(8'h30);
        total++; if (im_we !== 1'b0 || im_addr !== 8'h30 || count !== 9'd0) begin bad++; $display("FAIL drop_reload got we=%0b addr=%0h cnt=%0d exp 0 30 0", im_we, im_addr, count); end
        im_ready = 1'b1;
        step();
        total++; if (count !== 9'd0 || im_addr !== 8'h30) begin bad++; $display("FAIL drop_nowrite got cnt=%0d addr=%0h exp 0 30", count, im_addr); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_stall();
        test_ebreak();
        test_err();
        test_wrap();
        test_start_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
